// File: rtl/sliced_logic_pipe.sv
// ---------------------------------------------------------------------------
// sliced_logic_pipe
//
// Registered bit-sliced logic stage with a valid/ready handshake on both
// sides. The low NUM_SLICES*SLICE_W bits of A and B are cut into slices of
// SLICE_W bits. Each slice is cut into 4-bit groups, and every group goes
// through a fixed NOT/NAND network. Any slice whose slice_en bit is low
// produces zeros. Bits above the sliced region are always zero. The result
// is held in one output register (latency 1). Because in_ready looks ahead
// through out_ready, the stage runs at full throughput.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   A / B / slice_en carry a beat
//   in_ready   beat accepted this cycle (= !out_valid || out_ready)
//   A, B       BUS_W-bit operands
//   slice_en   per-slice enable, sampled with the beat
//   out_valid  C holds a result
//   out_ready  downstream accepts C
//   C          registered result
//   beat_cnt   saturating count of accepted beats
// ---------------------------------------------------------------------------
module sliced_logic_pipe #(
    parameter int BUS_W      = 41,
    parameter int SLICE_W    = 12,
    parameter int NUM_SLICES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_W-1:0]      A,
    input  logic [BUS_W-1:0]      B,
    input  logic [NUM_SLICES-1:0] slice_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_W-1:0]      C,
    output logic [15:0]           beat_cnt
);

    localparam int GROUPS = SLICE_W / 4;

    generate
        if ((SLICE_W % 4) != 0 || SLICE_W <= 0) begin : g_bad_slice_w
            $error("sliced_logic_pipe: SLICE_W must be a positive multiple of 4");
        end
        if (NUM_SLICES * SLICE_W > BUS_W) begin : g_bad_bus_w
            $error("sliced_logic_pipe: NUM_SLICES*SLICE_W exceeds BUS_W");
        end
    endgenerate

    // One 4-bit group. Bit 0 is ~a0. Bits 1 and 2 pass B shifted up by one,
    // inverted. Bit 3 is a three-term NAND of ORed operand pairs.
    function automatic logic [3:0] group_logic(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        r[0] = ~a[0];
        r[1] = ~b[0];
        r[2] = ~b[1];
        r[3] = ~((a[1] | a[2]) & (b[1] | b[2]) & (a[3] | b[3]));
        return r;
    endfunction

    logic             accept;
    logic [BUS_W-1:0] next_c;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: defaulting every bit first covers the disabled slices and the
        // bits above the sliced region, and keeps this block from inferring a latch.
        next_c = '0;
        for (int s = 0; s < NUM_SLICES; s++) begin
            if (slice_en[s]) begin
                for (int g = 0; g < GROUPS; g++) begin
                    next_c[s*SLICE_W + 4*g +: 4] =
                        group_logic(A[s*SLICE_W + 4*g +: 4], B[s*SLICE_W + 4*g +: 4]);
                end
            end
        end
    end

    // Reset is checked before anything else. A beat that arrives during
    // reset is dropped, and so is any result still waiting to be taken.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            C         <= '0;
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                C         <= next_c;
                out_valid <= 1'b1;
                if (beat_cnt != 16'hFFFF) begin
                    beat_cnt <= beat_cnt + 16'd1;
                end
            end else if (out_ready) begin
                // Result consumed with nothing behind it. C keeps its last value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule
